// File: rtl/first_indices.sv
// Registered lowest-0 / lowest-1 index finder with found flags, one clock of latency.
// Optional registered population count on ones_count when FIRST_INDICES_COUNT_EN is defined.
module first_indices #(
   parameter  int WIDTH = 4,
   localparam int IW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] num,
   output logic             out_valid,
   output logic [IW-1:0]    index0,
   output logic             found0,
   output logic [IW-1:0]    index1,
   output logic             found1
`ifdef FIRST_INDICES_COUNT_EN
   ,
   output logic [IW:0]      ones_count
`endif
);

   // Reject widths the index encoding cannot represent cleanly.
   if (WIDTH < 2 || WIDTH > 32 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("first_indices: WIDTH must be a power of two between 2 and 32");
   end

   logic [IW-1:0] idx0_c;
   logic [IW-1:0] idx1_c;
   logic          fnd0_c;
   logic          fnd1_c;

   // Scanning from the MSB down lets the lowest matching bit overwrite the rest.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      idx0_c = '0;
      idx1_c = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!num[i]) idx0_c = IW'(i);
         if (num[i])  idx1_c = IW'(i);
      end
      fnd0_c = ~&num;
      fnd1_c = |num;
   end

`ifdef FIRST_INDICES_COUNT_EN
   logic [IW:0] cnt_c;

   always_comb begin
      cnt_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_c = cnt_c + {{IW{1'b0}}, num[i]};
      end
   end
`endif

   // Results hold across idle cycles; only out_valid follows in_valid every edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         index0    <= '0;
         found0    <= 1'b0;
         index1    <= '0;
         found1    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         out_valid <= in_valid;
         if (in_valid) begin
            index0 <= idx0_c;
            found0 <= fnd0_c;
            index1 <= idx1_c;
            found1 <= fnd1_c;
         end
      end
   end

`ifdef FIRST_INDICES_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_count <= '0;
      end else if (in_valid) begin
         ones_count <= cnt_c;
      end
   end
`endif

endmodule

// File: tb/tb_first_indices.sv
// Directed self-checking bench for first_indices at WIDTH=4; expected values are hand-computed.
module tb_first_indices;

   localparam int WIDTH = 4;
   localparam int IW    = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] num;
   logic             out_valid;
   logic [IW-1:0]    index0;
   logic             found0;
   logic [IW-1:0]    index1;
   logic             found1;
`ifdef FIRST_INDICES_COUNT_EN
   logic [IW:0]      ones_count;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   first_indices #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .num        (num),
      .out_valid  (out_valid),
      .index0     (index0),
      .found0     (found0),
      .index1     (index1),
      .found1     (found1)
`ifdef FIRST_INDICES_COUNT_EN
      ,
      .ones_count (ones_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // cnt is only compared when the population-count output is built in.
   task automatic expect_out(input string tag, input logic ov, input int i0, input logic f0,
                             input int i1, input logic f1, input int cnt);
      check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
      check({tag, ".index0"},    32'(index0), 32'(i0));
      check({tag, ".found0"},    {31'd0, found0}, {31'd0, f0});
      check({tag, ".index1"},    32'(index1), 32'(i1));
      check({tag, ".found1"},    {31'd0, found1}, {31'd0, f1});
`ifdef FIRST_INDICES_COUNT_EN
      check({tag, ".ones_count"}, 32'(ones_count), 32'(cnt));
`else
      if (cnt < 0) $error("FAIL %s: negative count", tag);
`endif
   endtask

   task automatic send(input logic [WIDTH-1:0] v);
      @(negedge clk);
      in_valid = 1'b1;
      num      = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      num      = '0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      num      = '0;
      #12;
      expect_out("reset", 1'b0, 0, 1'b0, 0, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      expect_out("post_reset_idle", 1'b0, 0, 1'b0, 0, 1'b0, 0);

      send(4'd12);
      expect_out("num12", 1'b1, 0, 1'b1, 2, 1'b1, 2);
      send(4'd15);
      expect_out("num15", 1'b1, 0, 1'b0, 0, 1'b1, 4);
      send(4'd7);
      expect_out("num7", 1'b1, 3, 1'b1, 0, 1'b1, 3);
      send(4'd0);
      expect_out("num0", 1'b1, 0, 1'b1, 0, 1'b0, 0);
      send(4'd8);
      expect_out("num8", 1'b1, 0, 1'b1, 3, 1'b1, 1);
      send(4'd5);
      expect_out("num5", 1'b1, 1, 1'b1, 0, 1'b1, 2);
      idle();
      expect_out("idle_hold5", 1'b0, 1, 1'b1, 0, 1'b1, 2);

      // Back-to-back stream, then idle with hold of the last word.
      send(4'd12);
      expect_out("stream12", 1'b1, 0, 1'b1, 2, 1'b1, 2);
      send(4'd15);
      expect_out("stream15", 1'b1, 0, 1'b0, 0, 1'b1, 4);
      send(4'd7);
      expect_out("stream7", 1'b1, 3, 1'b1, 0, 1'b1, 3);
      idle();
      expect_out("stream_drop", 1'b0, 3, 1'b1, 0, 1'b1, 3);
      idle();
      expect_out("stream_hold", 1'b0, 3, 1'b1, 0, 1'b1, 3);

      // Asynchronous reset in the middle of a stream.
      send(4'd10);
      expect_out("num10", 1'b1, 0, 1'b1, 1, 1'b1, 2);
      send(4'd1);
      expect_out("num1", 1'b1, 1, 1'b1, 0, 1'b1, 1);
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("async_reset", 1'b0, 0, 1'b0, 0, 1'b0, 0);
      @(posedge clk);
      #1;
      expect_out("reset_held", 1'b0, 0, 1'b0, 0, 1'b0, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      expect_out("reset_release", 1'b0, 0, 1'b0, 0, 1'b0, 0);
      send(4'd14);
      expect_out("num14", 1'b1, 0, 1'b1, 1, 1'b1, 3);
      idle();
      expect_out("final_hold", 1'b0, 0, 1'b1, 1, 1'b1, 3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
